// File: rtl/stopwatch_ctrl.sv
// Purpose : stopwatch control FSM (IDLE/RUN/PAUSE/LAP), centisecond prescaler and mm:ss.cc counters.
// Latency : key event in cycle N is visible in cycle N+1; first cs tick lands CLK_PER_CS+1 cycles after a start event.
// Backpressure: none; key inputs are edge-detected every cycle and never stalled.
//
// Ports:
//   clk, sys_rst        clock and synchronous active-high reset
//   key_ss, key_cl      debounced start/stop and clear/lap key levels (rising edge = event)
//   disp_min/sec/cs     displayed time: frozen lap value in LAP, live counters otherwise
//   running, lap_active state decodes: time advancing / display frozen
//   wrap                one-cycle pulse after the 59:59.99 -> 00:00.00 rollover
module stopwatch_ctrl #(
    parameter int CLK_PER_CS = 10,
    parameter int PRESC_W    = 10
) (
    input  logic       clk,
    input  logic       sys_rst,
    input  logic       key_ss,
    input  logic       key_cl,
    output logic [5:0] disp_min,
    output logic [5:0] disp_sec,
    output logic [6:0] disp_cs,
    output logic       running,
    output logic       lap_active,
    output logic       wrap
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_CS - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    state_t             state_q;
    state_t             state_nxt;
    logic               key_ss_d;
    logic               key_cl_d;
    logic               ss_ev;
    logic               cl_ev;
    logic               lap_load;
    logic               live_clr;
    logic               count_en;
    logic               cs_tick;
    logic               cs_max;
    logic               sec_max;
    logic               min_max;
    logic [PRESC_W-1:0] presc_q;
    logic [5:0]         min_q;
    logic [5:0]         sec_q;
    logic [6:0]         cs_q;
    logic [5:0]         lap_min_q;
    logic [5:0]         lap_sec_q;
    logic [6:0]         lap_cs_q;
    logic               wrap_q;

    assign ss_ev = key_ss & ~key_ss_d;
    assign cl_ev = key_cl & ~key_cl_d;

    // Next-state logic; start/stop wins over clear/lap when both fire together.
    always_comb begin
        state_nxt = state_q;
        lap_load  = 1'b0;
        live_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ss_ev) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (ss_ev) begin
                    state_nxt = ST_PAUSE;
                end else if (cl_ev) begin
                    state_nxt = ST_LAP;
                    lap_load  = 1'b1;
                end
            end
            ST_LAP: begin
                if (ss_ev)      state_nxt = ST_PAUSE;
                else if (cl_ev) state_nxt = ST_RUN;
            end
            ST_PAUSE: begin
                if (ss_ev) begin
                    state_nxt = ST_RUN;
                end else if (cl_ev) begin
                    state_nxt = ST_IDLE;
                    live_clr  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Counting follows the current state, so the edge that leaves RUN/LAP still counts
    // and the edge that enters RUN does not.
    assign count_en = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign cs_tick  = count_en && (presc_q == PRESC_LAST);
    assign cs_max   = (cs_q == 7'd99);
    assign sec_max  = (sec_q == 6'd59);
    assign min_max  = (min_q == 6'd59);

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            key_ss_d  <= 1'b0;
            key_cl_d  <= 1'b0;
            presc_q   <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            cs_q      <= '0;
            lap_min_q <= '0;
            lap_sec_q <= '0;
            lap_cs_q  <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            key_ss_d <= key_ss;
            key_cl_d <= key_cl;
            wrap_q   <= cs_tick && cs_max && sec_max && min_max;

            // Lap captures the pre-increment live value of this edge.
            if (lap_load) begin
                lap_min_q <= min_q;
                lap_sec_q <= sec_q;
                lap_cs_q  <= cs_q;
            end

            if (live_clr) begin
                presc_q <= '0;
                min_q   <= '0;
                sec_q   <= '0;
                cs_q    <= '0;
            end else if (count_en) begin
                // Prescaler is left untouched outside RUN/LAP so a resume keeps the partial tick.
                presc_q <= cs_tick ? '0 : presc_q + PRESC_ONE;
                if (cs_tick) begin
                    cs_q <= cs_max ? 7'd0 : cs_q + 7'd1;
                    if (cs_max) begin
                        sec_q <= sec_max ? 6'd0 : sec_q + 6'd1;
                        if (sec_max) begin
                            min_q <= min_max ? 6'd0 : min_q + 6'd1;
                        end
                    end
                end
            end
        end
    end

    assign running    = count_en;
    assign lap_active = (state_q == ST_LAP);
    assign wrap       = wrap_q;
    assign disp_min   = lap_active ? lap_min_q : min_q;
    assign disp_sec   = lap_active ? lap_sec_q : sec_q;
    assign disp_cs    = lap_active ? lap_cs_q  : cs_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: table of key sequences with constant expected displays,
// a per-cycle comparison against a tick-counting reference model, random key traffic,
// and a second instance at one cycle per centisecond for the full-hour rollover.
module tb_stopwatch_ctrl;

    localparam int CPC  = 10;
    localparam int FULL = 360000;   // centiseconds in one hour

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       sys_rst = 1'b1;
    logic       key_ss  = 1'b0;
    logic       key_cl  = 1'b0;
    logic [5:0] disp_min, disp_sec;
    logic [6:0] disp_cs;
    logic       running, lap_active, wrap;

    logic       rst2    = 1'b1;
    logic       key_ss2 = 1'b0;
    logic       key_cl2 = 1'b0;
    logic [5:0] min2, sec2;
    logic [6:0] cs2;
    logic       run2, lap2, wrap2;

    stopwatch_ctrl #(.CLK_PER_CS(CPC), .PRESC_W(10)) dut (
        .clk(clk), .sys_rst(sys_rst), .key_ss(key_ss), .key_cl(key_cl),
        .disp_min(disp_min), .disp_sec(disp_sec), .disp_cs(disp_cs),
        .running(running), .lap_active(lap_active), .wrap(wrap)
    );

    stopwatch_ctrl #(.CLK_PER_CS(1), .PRESC_W(4)) dut_fast (
        .clk(clk), .sys_rst(rst2), .key_ss(key_ss2), .key_cl(key_cl2),
        .disp_min(min2), .disp_sec(sec2), .disp_cs(cs2),
        .running(run2), .lap_active(lap2), .wrap(wrap2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model: time kept as a raw count of enabled clocks
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;
    int m_mode   = M_IDLE;
    int m_ticks  = 0;
    int m_lap_cs = 0;
    bit m_wrap   = 1'b0;
    bit m_pss    = 1'b0;
    bit m_pcl    = 1'b0;

    function automatic void model_edge(bit rst, bit ss, bit cl);
        bit ssev, clev;
        int old_cs;
        if (rst) begin
            m_mode = M_IDLE; m_ticks = 0; m_lap_cs = 0; m_wrap = 1'b0;
            m_pss = 1'b0; m_pcl = 1'b0;
            return;
        end
        ssev   = ss && !m_pss;
        clev   = cl && !m_pcl;
        m_pss  = ss;
        m_pcl  = cl;
        old_cs = m_ticks / CPC;
        m_wrap = 1'b0;
        if (m_mode == M_RUN || m_mode == M_LAP) begin
            m_ticks++;
            if (m_ticks == CPC * FULL) begin
                m_ticks = 0;
                m_wrap  = 1'b1;
            end
        end
        if (ssev) begin
            m_mode = (m_mode == M_RUN || m_mode == M_LAP) ? M_PAUSE : M_RUN;
        end else if (clev) begin
            case (m_mode)
                M_RUN:   begin m_mode = M_LAP; m_lap_cs = old_cs; end
                M_LAP:   m_mode = M_RUN;
                M_PAUSE: begin m_mode = M_IDLE; m_ticks = 0; end
                default: ;
            endcase
        end
    endfunction

    task automatic check_disp(input string name, input int em, input int es, input int ec,
                              input bit er, input bit el);
        n_checks++;
        if (disp_min !== 6'(em) || disp_sec !== 6'(es) || disp_cs !== 7'(ec) ||
            running !== er || lap_active !== el) begin
            n_fail++;
            $display("FAIL %s: got %0d:%0d.%0d run=%0b lap=%0b, expected %0d:%0d.%0d run=%0b lap=%0b",
                     name, disp_min, disp_sec, disp_cs, running, lap_active, em, es, ec, er, el);
        end
    endtask

    task automatic check_model();
        int cs_tot;
        cs_tot = (m_mode == M_LAP) ? m_lap_cs : m_ticks / CPC;
        check_disp("model", cs_tot / 6000, (cs_tot / 100) % 60, cs_tot % 100,
                   (m_mode == M_RUN || m_mode == M_LAP), (m_mode == M_LAP));
        n_checks++;
        if (wrap !== m_wrap) begin
            n_fail++;
            $display("FAIL model wrap: got %0b, expected %0b", wrap, m_wrap);
        end
    endtask

    task automatic tick(input bit rst, input bit ss, input bit cl);
        sys_rst = rst;
        key_ss  = ss;
        key_cl  = cl;
        @(posedge clk);
        model_edge(rst, ss, cl);
        @(negedge clk);
        check_model();
    endtask

    task automatic check_fast(input string name, input int em, input int es, input int ec, input bit ew);
        n_checks++;
        if (min2 !== 6'(em) || sec2 !== 6'(es) || cs2 !== 7'(ec) || wrap2 !== ew) begin
            n_fail++;
            $display("FAIL %s: got %0d:%0d.%0d wrap=%0b, expected %0d:%0d.%0d wrap=%0b",
                     name, min2, sec2, cs2, wrap2, em, es, ec, ew);
        end
    endtask

    // ---------------- directed vectors: keys apply on the first cycle (or all cycles if hold)
    typedef struct {
        bit rst; bit ss; bit cl; bit hold; int n;
        int em; int es; int ec; bit er; bit el;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int wrap_cnt;

        //            rst ss cl hold  n     mm ss cc run lap
        vecs.push_back('{1, 0, 0, 1,    2,    0, 0, 0, 0, 0});  // reset state
        vecs.push_back('{0, 0, 0, 0,    4,    0, 0, 0, 0, 0});  // idle stays idle
        vecs.push_back('{0, 1, 0, 0,    1,    0, 0, 0, 1, 0});  // start
        vecs.push_back('{0, 0, 0, 0,    9,    0, 0, 0, 1, 0});  // one clock short of first tick
        vecs.push_back('{0, 0, 0, 0,    1,    0, 0, 1, 1, 0});  // first cs tick
        vecs.push_back('{0, 0, 0, 0,  990,    0, 1, 0, 1, 0});  // 1000 clocks -> 1 s
        vecs.push_back('{1, 0, 0, 1,    2,    0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0,    1,    0, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 0, 0,  250,    0, 0,25, 1, 0});
        vecs.push_back('{0, 1, 0, 0,    1,    0, 0,25, 0, 0});  // pause
        vecs.push_back('{0, 0, 0, 0,  500,    0, 0,25, 0, 0});  // held
        vecs.push_back('{0, 1, 0, 0,    1,    0, 0,25, 1, 0});  // resume
        vecs.push_back('{0, 0, 0, 0,  249,    0, 0,50, 1, 0});  // no partial tick lost
        vecs.push_back('{1, 0, 0, 1,    2,    0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0,    1,    0, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 2370,    0, 2,37, 1, 0});
        vecs.push_back('{0, 0, 1, 0,    1,    0, 2,37, 1, 1});  // lap capture
        vecs.push_back('{0, 0, 0, 0, 2629,    0, 2,37, 1, 1});  // frozen, live now 5.00
        vecs.push_back('{0, 0, 1, 0,    1,    0, 5, 0, 1, 0});  // release to live
        vecs.push_back('{0, 1, 1, 0,    2,    0, 5, 0, 0, 0});  // ss beats cl
        vecs.push_back('{0, 1, 0, 1,   50,    0, 5, 5, 1, 0});  // held ss: one event
        vecs.push_back('{0, 0, 0, 0,    5,    0, 5, 5, 1, 0});
        vecs.push_back('{0, 0, 1, 0,    1,    0, 5, 5, 1, 1});  // into LAP
        vecs.push_back('{1, 1, 0, 0,    1,    0, 0, 0, 0, 0});  // reset beats ss in LAP
        vecs.push_back('{0, 1, 0, 0,    1,    0, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 0, 0,  123,    0, 0,12, 1, 0});
        vecs.push_back('{0, 1, 0, 0,    1,    0, 0,12, 0, 0});  // pause
        vecs.push_back('{0, 0, 1, 0,    1,    0, 0, 0, 0, 0});  // clear from pause
        vecs.push_back('{0, 1, 0, 0,    1,    0, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 0, 0,    9,    0, 0, 0, 1, 0});  // prescaler was cleared
        vecs.push_back('{0, 0, 0, 0,    1,    0, 0, 1, 1, 0});

        foreach (vecs[v]) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                if (k == 0 || vecs[v].hold) tick(vecs[v].rst, vecs[v].ss, vecs[v].cl);
                else                        tick(1'b0, 1'b0, 1'b0);
            end
            check_disp($sformatf("vec%0d", v), vecs[v].em, vecs[v].es, vecs[v].ec,
                       vecs[v].er, vecs[v].el);
        end

        // ---------------- random key traffic against the model
        for (int i = 0; i < 5000; i++) begin
            tick(($urandom_range(0, 999) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        // ---------------- full-hour rollover at one clock per centisecond
        rst2 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_fast("fast reset", 0, 0, 0, 1'b0);
        rst2    = 1'b0;
        key_ss2 = 1'b1;
        @(negedge clk);
        key_ss2 = 1'b0;
        n_checks++;
        if (run2 !== 1'b1) begin
            n_fail++;
            $display("FAIL fast start: running got %0b, expected 1", run2);
        end
        wrap_cnt = 0;
        for (int i = 1; i < FULL; i++) begin
            @(negedge clk);
            if (wrap2) wrap_cnt++;
            if (i == 100)  check_fast("fast carry sec", 0, 1, 0, 1'b0);
            if (i == 6000) check_fast("fast carry min", 1, 0, 0, 1'b0);
        end
        check_fast("fast 59:59.99", 59, 59, 99, 1'b0);
        @(negedge clk);
        if (wrap2) wrap_cnt++;
        check_fast("fast rollover", 0, 0, 0, 1'b1);
        @(negedge clk);
        if (wrap2) wrap_cnt++;
        check_fast("fast after wrap", 0, 0, 1, 1'b0);
        n_checks++;
        if (wrap_cnt != 1) begin
            n_fail++;
            $display("FAIL fast wrap count: got %0d, expected 1", wrap_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
